// File: rtl/mdio_slave.sv
// MDIO (clause 22) management responder.
// The master's mdc/mdio are brought into the clk domain through 2-flop
// synchronizers. Every line sample and every change of drive happens on a
// detected mdc rising edge, so read data is stable when the master samples it
// on the following mdc fall. A 32 x 16 register file backs the frames.
// Registers 2 and 3 are the read-only PHY identifier words.

module mdio_slave #(
    parameter logic [4:0]  PHY_ADDRESS   = 5'h0c,
    parameter int          PREAMBLE_BITS = 32,
    parameter logic [15:0] PHY_ID1       = 16'h2000,
    parameter logic [15:0] PHY_ID2       = 16'h5c90
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_t,
    output logic        wr_strobe,
    output logic [4:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        busy
);

    // The preamble counter must be able to hold PREAMBLE_BITS itself.
    // Keep it at least one bit wide so that preamble suppression (0) still elaborates.
    localparam int               PRE_W   = (PREAMBLE_BITS < 1) ? 1 : $clog2(PREAMBLE_BITS + 1);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PREAMBLE_BITS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_OPCODE,
        ST_PHYAD,
        ST_REGAD,
        ST_TA,
        ST_READ_DATA,
        ST_WRITE_DATA
    } state_t;

    // Synchronizer and edge-detect flops.
    logic mdc_meta;
    logic mdc_sync;
    logic mdc_prev;
    logic mdio_meta;
    logic mdio_sync;
    logic mdc_rise;

    // Frame state.
    state_t           state;
    logic [PRE_W-1:0] pre_cnt;
    logic [4:0]       bit_cnt;     // holds 0..16; never wraps in any state
    logic             is_read;
    logic [15:0]      shift_reg;   // collects header/write bits, shifts out read data
    logic [4:0]       reg_addr;

    // Register file.
    logic [15:0]      regs [0:31];
    logic [15:0]      rd_value;

    // Bring mdc and mdio into the clk domain; mdc_prev feeds the edge detector.
    // NOTE: sequential state uses non-blocking assignments so that every flop
    // samples its pre-edge inputs, whatever the statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mdc_meta  <= 1'b0;
            mdc_sync  <= 1'b0;
            mdc_prev  <= 1'b0;
            mdio_meta <= 1'b0;
            mdio_sync <= 1'b0;
        end else begin
            mdc_meta  <= mdc;
            mdc_sync  <= mdc_meta;
            mdc_prev  <= mdc_sync;
            mdio_meta <= mdio_i;
            mdio_sync <= mdio_meta;
        end
    end

    // One-clk pulse on each synchronized mdc rising edge. mdio passes through the
    // same two-flop delay as mdc, so mdio_sync is the value present at that rise.
    assign mdc_rise = mdc_sync & ~mdc_prev;

    assign busy = (state != ST_IDLE);

    // Read mux: identifier words come straight from parameters, the rest from storage.
    // NOTE: rd_value gets a default before the case so that no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        rd_value = regs[reg_addr];
        case (reg_addr)
            5'd2:    rd_value = PHY_ID1;
            5'd3:    rd_value = PHY_ID2;
            default: rd_value = regs[reg_addr];
        endcase
    end

    // Commit writes one clk after the strobe; the identifier slots are never written.
    // NOTE: this storage is reset on purpose because the writable registers must
    // read back as zero after reset. That prevents mapping it onto RAM macros.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_strobe && (wr_addr != 5'd2) && (wr_addr != 5'd3)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Frame decoder: advances only on a detected mdc rise; wr_strobe lasts one clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            pre_cnt   <= '0;
            bit_cnt   <= '0;
            is_read   <= 1'b0;
            shift_reg <= '0;
            reg_addr  <= '0;
            mdio_o    <= 1'b0;
            mdio_t    <= 1'b1;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            wr_strobe <= 1'b0;
            if (mdc_rise) begin
                case (state)
                    ST_IDLE: begin
                        bit_cnt <= '0;
                        if (mdio_sync) begin
                            // The counter saturates, so reaching PRE_MAX is the same as passing it.
                            if (pre_cnt != PRE_MAX) begin
                                pre_cnt <= pre_cnt + PRE_W'(1);
                            end
                        end else if (pre_cnt == PRE_MAX) begin
                            // First start bit seen. Clear the counter now so that every
                            // frame exit returns to IDLE with a cleared counter.
                            state   <= ST_START;
                            pre_cnt <= '0;
                        end else begin
                            pre_cnt <= '0;
                        end
                    end

                    ST_START: begin
                        if (mdio_sync) begin
                            state   <= ST_OPCODE;
                            bit_cnt <= '0;
                        end else begin
                            state   <= ST_IDLE;
                            pre_cnt <= '0;
                        end
                    end

                    ST_OPCODE: begin
                        shift_reg <= {shift_reg[14:0], mdio_sync};
                        if (bit_cnt == 5'd0) begin
                            bit_cnt <= 5'd1;
                        end else begin
                            bit_cnt <= '0;
                            case ({shift_reg[0], mdio_sync})
                                2'b10: begin
                                    is_read <= 1'b1;
                                    state   <= ST_PHYAD;
                                end
                                2'b01: begin
                                    is_read <= 1'b0;
                                    state   <= ST_PHYAD;
                                end
                                default: begin
                                    state   <= ST_IDLE;
                                    pre_cnt <= '0;
                                end
                            endcase
                        end
                    end

                    ST_PHYAD: begin
                        shift_reg <= {shift_reg[14:0], mdio_sync};
                        if (bit_cnt == 5'd4) begin
                            bit_cnt <= '0;
                            if ({shift_reg[3:0], mdio_sync} == PHY_ADDRESS) begin
                                state <= ST_REGAD;
                            end else begin
                                state   <= ST_IDLE;
                                pre_cnt <= '0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end

                    ST_REGAD: begin
                        shift_reg <= {shift_reg[14:0], mdio_sync};
                        if (bit_cnt == 5'd4) begin
                            bit_cnt  <= '0;
                            reg_addr <= {shift_reg[3:0], mdio_sync};
                            state    <= ST_TA;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end

                    ST_TA: begin
                        if (is_read) begin
                            // End of the released TA bit: drive the TA zero and
                            // capture the word that will be shifted out.
                            mdio_t    <= 1'b0;
                            mdio_o    <= 1'b0;
                            shift_reg <= rd_value;
                            bit_cnt   <= '0;
                            state     <= ST_READ_DATA;
                        end else if (bit_cnt == 5'd0) begin
                            if (mdio_sync) begin
                                bit_cnt <= 5'd1;
                            end else begin
                                state   <= ST_IDLE;
                                pre_cnt <= '0;
                            end
                        end else begin
                            bit_cnt <= '0;
                            if (!mdio_sync) begin
                                state <= ST_WRITE_DATA;
                            end else begin
                                state   <= ST_IDLE;
                                pre_cnt <= '0;
                            end
                        end
                    end

                    ST_READ_DATA: begin
                        if (bit_cnt == 5'd16) begin
                            // Bit 0 has been on the line for a full period; let go.
                            mdio_t  <= 1'b1;
                            mdio_o  <= 1'b0;
                            bit_cnt <= '0;
                            pre_cnt <= '0;
                            state   <= ST_IDLE;
                        end else begin
                            mdio_o    <= shift_reg[15];
                            shift_reg <= {shift_reg[14:0], 1'b0};
                            bit_cnt   <= bit_cnt + 5'd1;
                        end
                    end

                    ST_WRITE_DATA: begin
                        shift_reg <= {shift_reg[14:0], mdio_sync};
                        if (bit_cnt == 5'd15) begin
                            // Strobe even for read-only addresses; storage filters those.
                            wr_strobe <= 1'b1;
                            wr_addr   <= reg_addr;
                            wr_data   <= {shift_reg[14:0], mdio_sync};
                            bit_cnt   <= '0;
                            pre_cnt   <= '0;
                            state     <= ST_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end

                    default: begin
                        state   <= ST_IDLE;
                        pre_cnt <= '0;
                        mdio_t  <= 1'b1;
                        mdio_o  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/mdio_slave.md
MDIO_SLAVE -- requirements
Module: mdio_slave

Interface
REQ-001 Parameter PHY_ADDRESS, 5'h0c, MDIO address this responder answers to.
REQ-002 Parameter PREAMBLE_BITS, 32, consecutive sampled 1s required before a start; 0 means preamble suppression.
REQ-003 Parameter PHY_ID1, 16'h2000, read-only content of register 2.
REQ-004 Parameter PHY_ID2, 16'h5c90, read-only content of register 3.
REQ-005 clk  input  1  system clock; one clock, all logic on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 mdc  input  1  management clock from master, asynchronous to clk, at most clk/8.
REQ-008 mdio_i  input  1  MDIO line as seen by this block.
REQ-009 mdio_o  output  1  MDIO drive value.
REQ-010 mdio_t  output  1  tristate enable, 1 = released (high-Z).
REQ-011 wr_strobe  output  1  one-clk pulse when a register write commits.
REQ-012 wr_addr  output  5  register address of committed write, valid with wr_strobe.
REQ-013 wr_data  output  16  data of committed write, valid with wr_strobe.
REQ-014 busy  output  1  high while state is not IDLE.

Function
REQ-015 mdc and mdio_i pass through 2-flop synchronizers; mdc edges detected on synchronized copy, yielding one-clk rise/fall pulses.
REQ-016 All line sampling occurs on detected mdc rise, using synchronized mdio_i.
REQ-017 All drive changes (mdio_o, mdio_t) occur on detected mdc rise, so data is stable for a master sampling on mdc fall.
REQ-018 Register file: 32 x 16 bits; registers 2 and 3 return PHY_ID1/PHY_ID2 and ignore writes; all others read/write.
REQ-019 States: IDLE, START, OPCODE, PHYAD, REGAD, TA, READ_DATA, WRITE_DATA.
REQ-020 IDLE: sampled 1 increments preamble counter, saturating at PREAMBLE_BITS; sampled 0 with counter >= PREAMBLE_BITS -> START; sampled 0 otherwise clears counter.
REQ-021 START: sampled 1 -> OPCODE; sampled 0 -> IDLE, counter cleared.
REQ-022 OPCODE: 2 bits MSB first; 10 = read, 01 = write; 00 or 11 -> IDLE, counter cleared.
REQ-023 PHYAD: 5 bits MSB first; mismatch with PHY_ADDRESS -> IDLE after 5th bit, counter cleared, no drive.
REQ-024 REGAD: 5 bits MSB first, latched; then -> TA.
REQ-025 Read TA: first TA period mdio_t stays 1; at the mdc rise ending it, mdio_t=0, mdio_o=0.
REQ-026 READ_DATA: at each following rise drive next bit of latched register, bit 15 first, 16 bits total.
REQ-027 After bit 0 period, next rise sets mdio_t=1, mdio_o=0, state IDLE, counter cleared.
REQ-028 Write TA: sampled bits must be 1 then 0; any mismatch -> IDLE, no write.
REQ-029 WRITE_DATA: 16 bits sampled MSB first; on 16th bit, register updated (unless read-only) and wr_strobe pulses for exactly one clk with wr_addr/wr_data, also pulsed for read-only addresses; -> IDLE.
REQ-030 mdio_t is 1 at all times except REQ-025..REQ-026 drive window; block never drives during a write or foreign-address frame.
REQ-031 Bit counters sized to hold 16; no wrap visible on outputs.

Reset
REQ-032 reset asserted: mdio_t=1, mdio_o=0, wr_strobe=0, wr_addr=0, wr_data=0, busy=0, state IDLE, preamble counter 0, synchronizers 0, R/W registers 0, effective immediately without clk.
REQ-033 reset mid-frame aborts the frame; no write commits; a fresh preamble (per PREAMBLE_BITS) is needed afterward.

Verification
REQ-034 32 ones, 01, 10, 01100, 00010, master releases -> slave Z for 1 bit, drives 0, then 16'h2000 MSB first, then mdio_t=1.
REQ-035 32 ones, write to reg 5 with TA 10, data 16'hBEEF -> wr_strobe one clk, wr_addr=5, wr_data=16'hBEEF; subsequent read of reg 5 returns 16'hBEEF.
REQ-036 Frame with PHY address 5'h01 -> mdio_t stays 1 throughout, busy falls after PHYAD, no wr_strobe.
REQ-037 Only 31 preamble ones then start -> ignored, mdio_t=1; with PREAMBLE_BITS=0, start with no preamble read of reg 3 -> 16'h5c90.
REQ-038 Write with TA 11 -> no write, reg unchanged; write of 16'h1234 to reg 2 -> wr_strobe pulses, read returns PHY_ID1.
REQ-039 reset asserted during READ_DATA bit 8 -> mdio_t=1 before next clk edge; next valid frame reads correctly.
